// File: rtl/ram_arb2_pkg.sv
// ram_arb_pkg: shared definitions for the two-requester RAM controller.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address / data widths
//   DEPTH                   : number of RAM words covered by the zero-fill
//   state_e                 : controller states (zero-fill, normal service)
//   RW_READ / RW_WRITE      : encodings of the rw pins on both sides
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 32'd8;
  localparam int DATA_W_DEF = 32'd32;
  localparam int DEPTH      = 32'd256;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/ram_arb2_if.sv
// ram_arb2_if: one requester's request/response channel to the RAM controller.
//   valid/ready    : request handshake (transfer when both high at posedge)
//   rw/adrs/wdata  : access type, word address, write data
//   rsp_valid      : one-cycle pulse carrying read data for an accepted read
//   rsp_rdata      : read data, zero whenever rsp_valid is low
// Modports: master = requester side, slave = controller side.
interface ram_arb2_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              valid;
  logic              ready;
  logic              rw;
  logic [ADDR_W-1:0] adrs;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output valid, rw, adrs, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, rw, adrs, wdata,
    output ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_arb2_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst : clock and synchronous active-high reset
//   req[1:0] : request bits, one per requester
//   adv      : when high, a grant this cycle moves priority to the other side
//   gnt[1:0] : one-hot grant, combinational from req and the priority pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic prio_r;

  // Grant select: a lone request always wins, a tie goes to the priority holder.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_r ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Priority pointer: after serving one side, the other side holds priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r <= 1'b0;
    end else if (adv && (gnt != 2'b00)) begin
      prio_r <= gnt[0];
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/ram_arb2.sv
// ram_arb2: controller for a single-port synchronous RAM shared by two requesters.
// After reset it zero-fills every word (if INIT_EN), then grants one access per
// cycle with round-robin fairness; read data returns exactly one cycle later.
//   clk, rst          : clock, synchronous active-high reset
//   req0, req1        : requester channels (ram_arb2_if slave side)
//   init_done         : high once the zero-fill is complete
//   ram_cs            : RAM chip select, active-low
//   ram_rw            : RAM access type (0 read, 1 write)
//   ram_adrs          : RAM word address
//   ram_data_in       : RAM write data
//   ram_data_out      : RAM registered read data
module ram_arb2
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter bit INIT_EN = 1'b1
)(
  input  logic              clk,
  input  logic              rst,
  ram_arb2_if.slave         req0,
  ram_arb2_if.slave         req1,
  output logic              init_done,
  output logic              ram_cs,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_adrs,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [ADDR_W-1:0] FILL_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              init_done_r;
  logic [1:0]        pend_r;
  logic              run_s;
  logic [1:0]        req_s;
  logic [1:0]        gnt_s;
  logic              hold_rw_r;
  logic [ADDR_W-1:0] hold_adrs_r;
  logic [DATA_W-1:0] hold_data_r;

  // Requests only reach the arbiter in the run state and outside reset, so
  // ready is low during the fill and while rst is asserted.
  always_comb begin
    run_s = (state_r == ST_RUN) && !rst;
    req_s = {req1.valid, req0.valid} & {2{run_s}};
  end

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_s),
    .adv (run_s),
    .gnt (gnt_s)
  );

  // Handshake and read-response outputs; rst suppresses an in-flight response.
  always_comb begin
    req0.ready     = gnt_s[0];
    req1.ready     = gnt_s[1];
    req0.rsp_valid = pend_r[0] & ~rst;
    req1.rsp_valid = pend_r[1] & ~rst;
    if (req0.rsp_valid) begin
      req0.rsp_rdata = ram_data_out;
    end else begin
      req0.rsp_rdata = {DATA_W{1'b0}};
    end
    if (req1.rsp_valid) begin
      req1.rsp_rdata = ram_data_out;
    end else begin
      req1.rsp_rdata = {DATA_W{1'b0}};
    end
  end

  // RAM pin mux: fill writes, granted access, or idle with the last values held.
  always_comb begin
    ram_cs      = 1'b1;
    ram_rw      = hold_rw_r;
    ram_adrs    = hold_adrs_r;
    ram_data_in = hold_data_r;
    if (rst) begin
      ram_cs      = 1'b1;
      ram_rw      = RW_READ;
      ram_adrs    = {ADDR_W{1'b0}};
      ram_data_in = {DATA_W{1'b0}};
    end else if (state_r == ST_INIT) begin
      ram_cs      = 1'b0;
      ram_rw      = RW_WRITE;
      ram_adrs    = cnt_r;
      ram_data_in = {DATA_W{1'b0}};
    end else if (gnt_s[0]) begin
      ram_cs      = 1'b0;
      ram_rw      = req0.rw;
      ram_adrs    = req0.adrs;
      ram_data_in = req0.wdata;
    end else if (gnt_s[1]) begin
      ram_cs      = 1'b0;
      ram_rw      = req1.rw;
      ram_adrs    = req1.adrs;
      ram_data_in = req1.wdata;
    end else begin
      ram_cs      = 1'b1;
    end
  end

  // Hold registers: remember what was last driven so idle cycles keep the pins steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_rw_r   <= RW_READ;
      hold_adrs_r <= {ADDR_W{1'b0}};
      hold_data_r <= {DATA_W{1'b0}};
    end else begin
      hold_rw_r   <= ram_rw;
      hold_adrs_r <= ram_adrs;
      hold_data_r <= ram_data_in;
    end
  end

  // Controller FSM: fill counter, init_done flag and read-pending bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= INIT_EN ? ST_INIT : ST_RUN;
      cnt_r       <= {ADDR_W{1'b0}};
      init_done_r <= ~INIT_EN;
      pend_r      <= 2'b00;
    end else begin
      // The RAM returns data for a read on the edge it was accepted, so the
      // response is flagged for exactly the following cycle.
      pend_r <= {gnt_s[1] & (req1.rw == RW_READ), gnt_s[0] & (req0.rw == RW_READ)};
      case (state_r)
        ST_INIT: begin
          // Counter parks at the last address rather than wrapping.
          if (cnt_r == FILL_LAST) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + ADR_ONE;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
    end
  end

  assign init_done = init_done_r;

endmodule

// File: tb/tb_ram_arb2.sv
// tb_ram_arb2: self-checking bench for ram_arb2 with a behavioural 256x32 RAM.
// A negedge monitor keeps a reference memory, pushes expected read data per
// requester when a read handshake is seen, and pops/compares on responses.
module tb_ram_arb2;
  import ram_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arb2_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  ram_arb2_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

  logic          init_done;
  logic          ram_cs;
  logic          ram_rw;
  logic [AW-1:0] ram_adrs;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;

  ram_arb2 #(.ADDR_W(AW), .DATA_W(DW), .INIT_EN(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (if0),
    .req1         (if1),
    .init_done    (init_done),
    .ram_cs       (ram_cs),
    .ram_rw       (ram_rw),
    .ram_adrs     (ram_adrs),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // Behavioural single-port RAM with registered read data and a poison preload.
  logic [DW-1:0] mem [0:255];
  logic          poison = 1'b0;
  always @(posedge clk) begin
    if (poison) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hDEADBEEF;
    end else if (!ram_cs) begin
      if (ram_rw) mem[ram_adrs] <= ram_data_in;
      else        ram_data_out  <= mem[ram_adrs];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard state
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  logic [1:0]    pend_exp = 2'b00;
  logic [1:0]    mon_pend;
  int            rsp_cnt0 = 0;
  int            rsp_cnt1 = 0;

  // Monitor: check responses against expectations, then record new handshakes.
  always @(negedge clk) begin
    if (rst) begin
      check_eq("rst_rsp0_valid", 32'(if0.rsp_valid), 32'd0);
      check_eq("rst_rsp1_valid", 32'(if1.rsp_valid), 32'd0);
      check_eq("rst_ready0", 32'(if0.ready), 32'd0);
      check_eq("rst_ready1", 32'(if1.ready), 32'd0);
      pend_exp = 2'b00;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      check_eq("rsp0_valid", 32'(if0.rsp_valid), 32'(pend_exp[0]));
      check_eq("rsp1_valid", 32'(if1.rsp_valid), 32'(pend_exp[1]));
      if (if0.rsp_valid && exp_q0.size() > 0) begin
        check_eq("rsp0_rdata", if0.rsp_rdata, exp_q0.pop_front());
        rsp_cnt0++;
      end else if (!if0.rsp_valid) begin
        check_eq("rsp0_rdata_idle", if0.rsp_rdata, 32'd0);
      end
      if (if1.rsp_valid && exp_q1.size() > 0) begin
        check_eq("rsp1_rdata", if1.rsp_rdata, exp_q1.pop_front());
        rsp_cnt1++;
      end else if (!if1.rsp_valid) begin
        check_eq("rsp1_rdata_idle", if1.rsp_rdata, 32'd0);
      end
      check_eq("one_grant", 32'(if0.ready & if1.ready), 32'd0);
      mon_pend = 2'b00;
      if (if0.valid && if0.ready) begin
        if (if0.rw == RW_WRITE) ref_mem[if0.adrs] = if0.wdata;
        else begin exp_q0.push_back(ref_mem[if0.adrs]); mon_pend[0] = 1'b1; end
      end
      if (if1.valid && if1.ready) begin
        if (if1.rw == RW_WRITE) ref_mem[if1.adrs] = if1.wdata;
        else begin exp_q1.push_back(ref_mem[if1.adrs]); mon_pend[1] = 1'b1; end
      end
      pend_exp = mon_pend;
    end
  end

  task automatic set_req(input int n, input logic v, input logic rw,
                         input logic [7:0] a, input logic [31:0] d);
    if (n == 0) begin
      if0.valid = v; if0.rw = rw; if0.adrs = a; if0.wdata = d;
    end else begin
      if1.valid = v; if1.rw = rw; if1.adrs = a; if1.wdata = d;
    end
  endtask

  function automatic logic get_ready(input int n);
    return (n == 0) ? if0.ready : if1.ready;
  endfunction

  // Issue one request (called just after a posedge); returns just after the
  // accepting edge with valid already dropped, so calls chain back-to-back.
  task automatic do_req(input int n, input logic rw, input logic [7:0] a, input logic [31:0] d);
    int w;
    w = 0;
    set_req(n, 1'b1, rw, a, d);
    @(negedge clk);
    while (!get_ready(n) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("req_accept", 32'(get_ready(n)), 32'd1);
    @(posedge clk); #1;
    set_req(n, 1'b0, RW_READ, 8'h00, 32'h0);
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic check_mem_zero(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 32'h0) nz++;
    check_eq(tag, 32'(nz), 32'd0);
  endtask

  // Count negedges from rst release until init_done (bounded); the first
  // cycle must show the fill starting at address 0.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (n < 400 && !(n > 0 && init_done)) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check_eq({tag, "_cs0"},   32'(ram_cs), 32'd0);
        check_eq({tag, "_adrs0"}, 32'(ram_adrs), 32'd0);
        check_eq({tag, "_done0"}, 32'(init_done), 32'd0);
      end
    end
    check_eq({tag, "_len"}, 32'(n), 32'd257);
  endtask

  int n;
  int first_rdy;
  int done_at;
  int c0;
  int c1;

  initial begin
    set_req(0, 1'b0, RW_READ, 8'h00, 32'h0);
    set_req(1, 1'b0, RW_READ, 8'h00, 32'h0);
    rst = 1'b1;
    poison = 1'b1;
    @(posedge clk); #1;
    poison = 1'b0;
    @(negedge clk);
    check_eq("reset_cs", 32'(ram_cs), 32'd1);
    check_eq("reset_rw", 32'(ram_rw), 32'd0);
    check_eq("reset_adrs", 32'(ram_adrs), 32'd0);
    check_eq("reset_din", ram_data_in, 32'd0);
    check_eq("reset_init_done", 32'(init_done), 32'd0);
    check_eq("poison_preload", mem[8'h7F], 32'hDEADBEEF);

    // Init fill with req0 already asking to read address 0x00.
    @(posedge clk); #1;
    set_req(0, 1'b1, RW_READ, 8'h00, 32'h0);
    clear_ref();
    rst = 1'b0;
    n = 0; first_rdy = 0; done_at = 0;
    while (n < 400 && first_rdy == 0) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check_eq("init_cs", 32'(ram_cs), 32'd0);
        check_eq("init_rw", 32'(ram_rw), 32'd1);
        check_eq("init_adrs", 32'(ram_adrs), 32'd0);
        check_eq("init_din", ram_data_in, 32'd0);
      end
      if (init_done && done_at == 0) done_at = n;
      if (if0.ready) first_rdy = n;
    end
    check_eq("init_done_cycle", 32'(done_at), 32'd257);
    check_eq("first_accept_cycle", 32'(first_rdy), 32'd257);
    @(posedge clk); #1;
    set_req(0, 1'b0, RW_READ, 8'h00, 32'h0);
    check_mem_zero("fill_nonzero_words");
    do_req(1, RW_READ, 8'h7F, 32'h0);
    do_req(0, RW_READ, 8'hFF, 32'h0);
    repeat (2) @(negedge clk);
    check_eq("init_reads_rsp0", 32'(rsp_cnt0), 32'd2);
    check_eq("init_reads_rsp1", 32'(rsp_cnt1), 32'd1);

    // Single access: write then read back on the next cycle.
    @(posedge clk); #1;
    do_req(0, RW_WRITE, 8'h3C, 32'h12345678);
    do_req(0, RW_READ, 8'h3C, 32'h0);
    @(negedge clk);
    check_eq("single_rsp0_valid", 32'(if0.rsp_valid), 32'd1);
    check_eq("single_rsp0_rdata", if0.rsp_rdata, 32'h12345678);
    check_eq("single_rsp1_valid", 32'(if1.rsp_valid), 32'd0);

    // Back-to-back: load distinct data, then stream reads on req1.
    @(posedge clk); #1;
    do_req(0, RW_WRITE, 8'h01, 32'h01010101);
    for (int i = 0; i < 8; i++) do_req(0, RW_WRITE, 8'(8'h10 + i), 32'hA5A50010 + 32'(i));
    do_req(1, RW_WRITE, 8'h02, 32'h02020202);
    c1 = rsp_cnt1;
    for (int i = 0; i < 8; i++) do_req(1, RW_READ, 8'(8'h10 + i), 32'h0);
    repeat (2) @(negedge clk);
    check_eq("stream_rsp1_count", 32'(rsp_cnt1 - c1), 32'd8);

    // Contention: last grant went to req1, so req0 holds priority.
    @(posedge clk); #1;
    c0 = rsp_cnt0; c1 = rsp_cnt1;
    set_req(0, 1'b1, RW_READ, 8'h01, 32'h0);
    set_req(1, 1'b1, RW_READ, 8'h02, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("cont_gnt0_%0d", i), 32'(if0.ready), 32'((i % 2) == 0));
      check_eq($sformatf("cont_gnt1_%0d", i), 32'(if1.ready), 32'((i % 2) == 1));
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, RW_READ, 8'h00, 32'h0);
    set_req(1, 1'b0, RW_READ, 8'h00, 32'h0);
    repeat (2) @(negedge clk);
    check_eq("cont_rsp0_count", 32'(rsp_cnt0 - c0), 32'd3);
    check_eq("cont_rsp1_count", 32'(rsp_cnt1 - c1), 32'd3);

    // Reset during init at fill counter 100.
    @(posedge clk); #1;
    rst = 1'b1;
    poison = 1'b1;
    @(posedge clk); #1;
    poison = 1'b0;
    rst = 1'b0;
    clear_ref();
    n = 0;
    @(negedge clk);
    while (n < 300 && ram_adrs != 8'd100) begin
      @(negedge clk);
      n++;
    end
    check_eq("reinit_reach_100", 32'(ram_adrs), 32'd100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init("reinit");
    check_mem_zero("reinit_nonzero_words");

    // Reset with a read in flight.
    @(posedge clk); #1;
    set_req(0, 1'b1, RW_READ, 8'h3C, 32'h0);
    @(negedge clk);
    check_eq("inflight_accept", 32'(if0.ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 1'b0, RW_READ, 8'h00, 32'h0);
    @(negedge clk);
    check_eq("inflight_rsp0_dropped", 32'(if0.rsp_valid), 32'd0);
    check_eq("inflight_cs", 32'(ram_cs), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_ref();
    wait_init("inflight_init");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 ns, expected to finish earlier");
    $fatal(1);
  end

endmodule
